// File: rtl/dunit_pkg.sv
// dunit_pkg: command/response bytes, HALT word and FSM states shared by the debug-unit controller.
package dunit_pkg;
    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_RSTPC = 8'h52;
    localparam logic [7:0] RSP_K     = 8'h4B;
    localparam logic [7:0] RSP_E     = 8'h45;
    localparam logic [7:0] RSP_H     = 8'h48;
    localparam logic [7:0] RSP_T     = 8'h54;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN, S_STEP, S_RSTPC, S_ACK} state_t;
endpackage

// File: rtl/dunit_word_packer.sv
// dunit_word_packer: MSB-first byte-to-word shift register; word_valid flags the byte completing a word.
module dunit_word_packer #(
    parameter int NB_REG  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               valid,
    input  logic [NB_BYTE-1:0] data,
    output logic [NB_REG-1:0]  word,
    output logic               word_valid
);
    localparam int NB_CNT = $clog2(NB_REG / NB_BYTE);
    logic [NB_CNT-1:0] cnt;
    assign word_valid = valid && cnt == NB_CNT'(NB_REG / NB_BYTE - 1);
    // Clearing only the counter drops a partial word; the word register holds for the write bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (valid) begin
            word <= {word[NB_REG-NB_BYTE-1:0], data};
            cnt  <= cnt + NB_CNT'(1);
        end
    end
endmodule

// File: rtl/dunit_ctrl.sv
// dunit_ctrl: UART-driven debug controller for the MIPS pipeline (load, run, step, PC reset).
// Define DUNIT_CYCLE_LIMIT_EN to add a MAX_CYCLES watchdog that ends RUN with response 'T'.
module dunit_ctrl
    import dunit_pkg::*;
#(
    parameter int NB_REG     = 32,
    parameter int NB_WIDHT   = 9,
    parameter int NB_BYTE    = 8,
    parameter int MAX_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_busy,
    input  logic               i_halt,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_reset_pc,
    output logic               o_dunit_w_en,
    output logic [NB_REG-1:0]  o_dunit_mem_addr,
    output logic [NB_REG-1:0]  o_dunit_mem_data,
    output logic [NB_REG-1:0]  o_cycle_count
);
    state_t state, state_n;
    logic [NB_WIDHT-3:0] idx;
    logic [NB_BYTE-1:0] ack, ack_n;
    logic halt_q, ran, limit, load_start, word_valid;
    logic [NB_REG-1:0] word;

    assign load_start = state == S_IDLE && i_rx_valid && i_rx_data == CMD_LOAD;

    dunit_word_packer #(.NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) u_packer (
        .clk       (i_clk),
        .rst       (i_reset),
        .clear     (load_start),
        .valid     (state == S_LOAD && i_rx_valid),
        .data      (i_rx_data),
        .word      (word),
        .word_valid(word_valid)
    );

`ifdef DUNIT_CYCLE_LIMIT_EN
    localparam int NB_RC = $clog2(MAX_CYCLES + 1);
    logic [NB_RC-1:0] run_cnt;
    assign limit = run_cnt == NB_RC'(MAX_CYCLES);
    always_ff @(posedge i_clk) begin
        if (i_reset || state != S_RUN)
            run_cnt <= '0;
        else if (o_dunit_clk_en)
            run_cnt <= run_cnt + NB_RC'(1);
    end
`else
    assign limit = 1'b0;
`endif

    // Enable decisions use the halt level registered on the previous edge.
    assign o_dunit_clk_en   = !halt_q && ((state == S_RUN && !limit) || state == S_STEP);
    assign o_dunit_w_en     = state == S_WRITE;
    assign o_dunit_reset_pc = state == S_RSTPC;
    assign o_tx_start       = state == S_ACK && !i_tx_busy;
    assign o_tx_data        = ack;
    assign o_dunit_mem_data = word;

    always_comb begin
        state_n = state;
        ack_n   = ack;
        case (state)
            S_IDLE: if (i_rx_valid) begin
                state_n = i_rx_data == CMD_LOAD  ? S_LOAD  :
                          i_rx_data == CMD_RUN   ? S_RUN   :
                          i_rx_data == CMD_STEP  ? S_STEP  :
                          i_rx_data == CMD_RSTPC ? S_RSTPC : S_ACK;
                ack_n   = RSP_E;
            end
            S_LOAD:  state_n = word_valid ? S_WRITE : S_LOAD;
            S_WRITE: begin
                state_n = (word == HALT_WORD || &idx) ? S_ACK : S_LOAD;
                ack_n   = word == HALT_WORD ? RSP_K : RSP_E;
            end
            S_RUN: if (halt_q) begin
                state_n = S_ACK;
                ack_n   = ran ? RSP_K : RSP_H;
            end else if (limit) begin
                state_n = S_ACK;
`ifdef DUNIT_CYCLE_LIMIT_EN
                ack_n   = RSP_T;
`endif
            end
            S_STEP: begin
                state_n = S_ACK;
                ack_n   = halt_q ? RSP_H : RSP_K;
            end
            S_RSTPC: begin
                state_n = S_ACK;
                ack_n   = RSP_K;
            end
            S_ACK:   state_n = i_tx_busy ? S_ACK : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= S_IDLE;
            ack              <= '0;
            idx              <= '0;
            halt_q           <= 1'b0;
            ran              <= 1'b0;
            o_dunit_mem_addr <= '0;
            o_cycle_count    <= '0;
        end else begin
            state  <= state_n;
            ack    <= ack_n;
            halt_q <= i_halt;
            ran    <= state == S_RUN && (ran || o_dunit_clk_en);
            if (load_start)
                idx <= '0;
            else if (state == S_WRITE)
                idx <= idx + 1'b1;
            if (word_valid)
                o_dunit_mem_addr <= NB_REG'({idx, 2'b00});
            if (state == S_RSTPC)
                o_cycle_count <= '0;
            else if (o_dunit_clk_en && !(&o_cycle_count))
                o_cycle_count <= o_cycle_count + 1'b1;
        end
    end
endmodule
